// File: rtl/tc_sram_pwr_pkg.sv
// Shared types and sizing helpers for the per-bank SRAM power controller.
// Bank power states and a counter-width helper that never returns zero.
package tc_sram_pwr_pkg;

    typedef enum logic [1:0] {
        PWR_ACTIVE = 2'd0,
        PWR_SLEEP  = 2'd1,
        PWR_OFF    = 2'd2,
        PWR_WAKE   = 2'd3
    } bank_pwr_state_e;

    // Width needed to hold 0..max_val; at least one bit so a zero limit still elaborates.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tc_sram_bank_pwr_fsm.sv
// Power-state FSM for one logic bank: idle timeout into SLEEP, software OFF,
// and a settling WAKE phase before the bank accepts accesses again.
module tc_sram_bank_pwr_fsm
    import tc_sram_pwr_pkg::*;
#(
    parameter int SleepIdleCycles = 64,
    parameter int WakeSleepCycles = 2,
    parameter int WakeOffCycles   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hit_i,
    input  logic            off_req_i,
    output bank_pwr_state_e state_o,
    output logic            deepsleep_o,
    output logic            powergate_o
);

    localparam int IdleW = cnt_width(SleepIdleCycles);
    localparam int WakeW = cnt_width(max_int(WakeSleepCycles, WakeOffCycles));

    localparam logic [IdleW-1:0] IdleLast =
        IdleW'((SleepIdleCycles > 0) ? SleepIdleCycles - 1 : 0);
    localparam logic [WakeW-1:0] WakeSleepInit =
        WakeW'((WakeSleepCycles > 0) ? WakeSleepCycles - 1 : 0);
    localparam logic [WakeW-1:0] WakeOffInit =
        WakeW'((WakeOffCycles > 0) ? WakeOffCycles - 1 : 0);

    bank_pwr_state_e  state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WakeW-1:0] wake_q, wake_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        unique case (state_q)
            PWR_ACTIVE: begin
                if (off_req_i) begin
                    state_d = PWR_OFF;
                end else if (hit_i) begin
                    idle_d = '0;
                end else if (SleepIdleCycles != 0) begin
                    if (idle_q == IdleLast) state_d = PWR_SLEEP;
                    else                    idle_d  = idle_q + 1'b1;
                end
            end
            PWR_SLEEP: begin
                if (off_req_i) begin
                    state_d = PWR_OFF;
                end else if (hit_i) begin
                    if (WakeSleepCycles == 0) begin
                        state_d = PWR_ACTIVE;
                        idle_d  = '0;
                    end else begin
                        state_d = PWR_WAKE;
                        wake_d  = WakeSleepInit;
                    end
                end
            end
            PWR_OFF: begin
                // Leaving OFF is driven by the release of off_req alone, not by traffic.
                if (!off_req_i) begin
                    if (WakeOffCycles == 0) begin
                        state_d = PWR_ACTIVE;
                        idle_d  = '0;
                    end else begin
                        state_d = PWR_WAKE;
                        wake_d  = WakeOffInit;
                    end
                end
            end
            PWR_WAKE: begin
                if (off_req_i) begin
                    state_d = PWR_OFF;
                end else if (wake_q == '0) begin
                    state_d = PWR_ACTIVE;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q - 1'b1;
                end
            end
            default: state_d = PWR_ACTIVE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PWR_ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
        end
    end

    assign state_o     = state_q;
    assign deepsleep_o = (state_q == PWR_SLEEP);
    assign powergate_o = (state_q == PWR_OFF);

endmodule

// File: rtl/tc_sram_bank_pwr_ctrl.sv
// Per-bank power controller in front of the power-gated multibank SRAM:
// decodes request banks, runs one power FSM per bank and gates grants.
module tc_sram_bank_pwr_ctrl
    import tc_sram_pwr_pkg::*;
#(
    parameter  int NumWords        = 1024,
    parameter  int NumPorts        = 2,
    parameter  int NumLogicBanks   = 4,
    parameter  int SleepIdleCycles = 64,
    parameter  int WakeSleepCycles = 2,
    parameter  int WakeOffCycles   = 8,
    localparam int AddrWidth       = $clog2(NumWords),
    localparam int BankSelWidth    = $clog2(NumLogicBanks)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumPorts-1:0]                req_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
    output logic [NumPorts-1:0]                gnt_o,
    output logic [NumPorts-1:0]                sram_req_o,
    input  logic [NumLogicBanks-1:0]           off_req_i,
    output logic [NumLogicBanks-1:0]           deepsleep_o,
    output logic [NumLogicBanks-1:0]           powergate_o,
    output logic [NumLogicBanks-1:0]           bank_active_o
);

    if (NumLogicBanks < 2 || (NumLogicBanks & (NumLogicBanks - 1)) != 0) begin : g_bad_banks
        $fatal(1, "NumLogicBanks must be a power of two and at least 2");
    end

    logic [NumPorts-1:0][BankSelWidth-1:0] bank_sel;
    logic [NumLogicBanks-1:0]              bank_hit;
    bank_pwr_state_e                       bank_state [NumLogicBanks];

    always_comb begin
        bank_sel = '0;
        bank_hit = '0;
        for (int p = 0; p < NumPorts; p++) begin
            bank_sel[p] = addr_i[p][AddrWidth-1 -: BankSelWidth];
            for (int b = 0; b < NumLogicBanks; b++) begin
                if (req_i[p] && bank_sel[p] == BankSelWidth'(b)) bank_hit[b] = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NumLogicBanks; b++) begin : g_bank
        tc_sram_bank_pwr_fsm #(
            .SleepIdleCycles (SleepIdleCycles),
            .WakeSleepCycles (WakeSleepCycles),
            .WakeOffCycles   (WakeOffCycles)
        ) u_fsm (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .hit_i       (bank_hit[b]),
            .off_req_i   (off_req_i[b]),
            .state_o     (bank_state[b]),
            .deepsleep_o (deepsleep_o[b]),
            .powergate_o (powergate_o[b])
        );
        assign bank_active_o[b] = (bank_state[b] == PWR_ACTIVE);
    end

    // A rising off_req blocks the grant in the same cycle, before the FSM reacts.
    always_comb begin
        gnt_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            gnt_o[p] = req_i[p] & bank_active_o[bank_sel[p]] & ~off_req_i[bank_sel[p]];
        end
    end

    assign sram_req_o = gnt_o;

endmodule

// File: tb/tb_tc_sram_bank_pwr_ctrl.sv
// Directed bench for tc_sram_bank_pwr_ctrl with SleepIdleCycles=4,
// WakeSleepCycles=2, WakeOffCycles=3: a vector table plus multi-cycle sequences.
module tb_tc_sram_bank_pwr_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0][9:0]  addr;
    logic [1:0]       gnt;
    logic [1:0]       sram_req;
    logic [3:0]       off;
    logic [3:0]       ds;
    logic [3:0]       pg;
    logic [3:0]       act;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tc_sram_bank_pwr_ctrl #(
        .NumWords        (1024),
        .NumPorts        (2),
        .NumLogicBanks   (4),
        .SleepIdleCycles (4),
        .WakeSleepCycles (2),
        .WakeOffCycles   (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .addr_i        (addr),
        .gnt_o         (gnt),
        .sram_req_o    (sram_req),
        .off_req_i     (off),
        .deepsleep_o   (ds),
        .powergate_o   (pg),
        .bank_active_o (act)
    );

    typedef struct {
        logic [1:0] req;
        int         b0;
        int         b1;
        logic [3:0] off;
        logic [1:0] gnt;
        logic [3:0] ds;
        logic [3:0] pg;
        logic [3:0] act;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] baddr(input int b);
        logic [9:0] a;
        a      = '0;
        a[9:8] = b[1:0];
        return a;
    endfunction

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic [1:0] r, input int b0, input int b1, input logic [3:0] o);
        req     = r;
        addr[0] = baddr(b0);
        addr[1] = baddr(b1);
        off     = o;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        off = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds a request until every requested port is granted; lat = -1 on timeout.
    task automatic measure_grant(input logic [1:0] r, input int b0, input int b1, output int lat);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            apply(r, b0, b1, 4'b0000);
            check("grant_all_or_none", 32'((gnt == 2'b00) || (gnt == r)), 32'd1);
            if (gnt == r) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int lat;
        rst  = 1'b1;
        req  = '0;
        addr = '0;
        off  = '0;

        //                 req    b0 b1 off      gnt    ds       pg       act
        tbl[0]  = '{2'b01, 0, 0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 4'b1111};
        tbl[1]  = '{2'b01, 0, 0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 4'b1111};
        tbl[2]  = '{2'b01, 0, 0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 4'b1111};
        tbl[3]  = '{2'b01, 0, 0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 4'b1111};
        tbl[4]  = '{2'b01, 0, 0, 4'b0000, 2'b01, 4'b1110, 4'b0000, 4'b0001};
        tbl[5]  = '{2'b11, 0, 1, 4'b0000, 2'b01, 4'b1110, 4'b0000, 4'b0001};
        tbl[6]  = '{2'b11, 0, 1, 4'b0000, 2'b01, 4'b1100, 4'b0000, 4'b0001};
        tbl[7]  = '{2'b11, 0, 1, 4'b0000, 2'b01, 4'b1100, 4'b0000, 4'b0001};
        tbl[8]  = '{2'b11, 0, 1, 4'b0000, 2'b11, 4'b1100, 4'b0000, 4'b0011};
        tbl[9]  = '{2'b11, 0, 0, 4'b0000, 2'b11, 4'b1100, 4'b0000, 4'b0011};
        tbl[10] = '{2'b01, 0, 0, 4'b0001, 2'b00, 4'b1100, 4'b0000, 4'b0011};
        tbl[11] = '{2'b01, 0, 0, 4'b0001, 2'b00, 4'b1100, 4'b0001, 4'b0010};
        tbl[12] = '{2'b01, 0, 0, 4'b0000, 2'b00, 4'b1100, 4'b0001, 4'b0010};
        tbl[13] = '{2'b01, 0, 0, 4'b0000, 2'b00, 4'b1110, 4'b0000, 4'b0000};
        tbl[14] = '{2'b01, 0, 0, 4'b0000, 2'b00, 4'b1110, 4'b0000, 4'b0000};
        tbl[15] = '{2'b01, 0, 0, 4'b0000, 2'b00, 4'b1110, 4'b0000, 4'b0000};
        tbl[16] = '{2'b01, 0, 0, 4'b0000, 2'b01, 4'b1110, 4'b0000, 4'b0001};

        // Reset state, and grant following req in the first cycle after reset.
        do_reset();
        apply(2'b10, 0, 3, 4'b0000);
        check("rst_deepsleep", ds, 4'b0000);
        check("rst_powergate", pg, 4'b0000);
        check("rst_active", act, 4'b1111);
        check("rst_gnt", gnt, 2'b10);
        tick();

        // Vector table: continuous bank-0 traffic, sleep/wake of bank 1,
        // off_req on bank 0 colliding with a hit, then wake from OFF.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].req, tbl[i].b0, tbl[i].b1, tbl[i].off);
            check($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
            check($sformatf("vec%0d_sram_req", i), sram_req, tbl[i].gnt);
            check($sformatf("vec%0d_deepsleep", i), ds, tbl[i].ds);
            check($sformatf("vec%0d_powergate", i), pg, tbl[i].pg);
            check($sformatf("vec%0d_active", i), act, tbl[i].act);
            tick();
        end

        // Idle timeout: last hit on bank 1 at t=2 -> deepsleep at t+5; request at t+10.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(2'b01, 1, 0, 4'b0000);
            tick();
        end
        for (int c = 1; c <= 4; c++) begin
            apply(2'b00, 0, 0, 4'b0000);
            check($sformatf("idle_t+%0d_awake", c), ds[1], 1'b0);
            tick();
        end
        apply(2'b00, 0, 0, 4'b0000);
        check("idle_t+5_asleep", ds[1], 1'b1);
        tick();
        repeat (4) begin
            apply(2'b00, 0, 0, 4'b0000);
            tick();
        end
        apply(2'b01, 1, 0, 4'b0000);
        check("sleep_req_ds", ds[1], 1'b1);
        check("sleep_req_gnt", gnt, 2'b00);
        tick();
        apply(2'b01, 1, 0, 4'b0000);
        check("wake_ds_low", ds[1], 1'b0);
        tick();
        measure_grant(2'b01, 1, 0, lat);
        check("sleep_wake_latency", lat, 32'd1);
        tick();

        // off_req on bank 2 for 8 cycles while port 1 requests bank 2.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            apply(2'b10, 0, 2, (k < 8) ? 4'b0100 : 4'b0000);
            check($sformatf("off_k%0d_powergate", k), pg[2], 1'((k >= 1) && (k <= 8)));
            check($sformatf("off_k%0d_gnt", k), gnt, (k >= 12) ? 2'b10 : 2'b00);
            tick();
        end

        // Both ports hit sleeping bank 3 together: granted together, 3 cycles later.
        do_reset();
        repeat (5) begin
            apply(2'b00, 0, 0, 4'b0000);
            tick();
        end
        apply(2'b00, 0, 0, 4'b0000);
        check("bank3_asleep", ds[3], 1'b1);
        measure_grant(2'b11, 3, 3, lat);
        check("dual_port_wake_latency", lat, 32'd3);
        tick();

        // Reset pulsed while bank 1 is in WAKE with a request pending.
        do_reset();
        repeat (5) begin
            apply(2'b00, 0, 0, 4'b0000);
            tick();
        end
        apply(2'b01, 1, 0, 4'b0000);
        tick();
        apply(2'b01, 1, 0, 4'b0000);
        check("wake_not_active", act[1], 1'b0);
        check("wake_no_deepsleep", ds[1], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply(2'b01, 1, 0, 4'b0000);
        check("rst_wake_deepsleep", ds, 4'b0000);
        check("rst_wake_powergate", pg, 4'b0000);
        check("rst_wake_active", act, 4'b1111);
        check("rst_wake_gnt", gnt, 2'b01);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
